// File: rtl/mc_control_unit_if.sv
// Instruction handshake plus datapath control bundle between the multi-cycle
// control unit (slave) and the fetch/datapath side (master).
interface mc_control_unit_if;
  logic [31:0] Instr;
  logic        Instr_Valid;
  logic        Instr_Ready;
  logic        Zero;
  logic        Mem_Ready;
  logic [4:0]  RR1;
  logic [4:0]  RR2;
  logic [4:0]  WR;
  logic        WE;
  logic [3:0]  ALU_Op;
  logic [4:0]  ShiftCount;
  logic [1:0]  ALUSrcB;
  logic        WB_Sel;
  logic        MemRead;
  logic        MemWrite;
  logic        PC_Inc;
  logic        PC_Write;
  logic [1:0]  PC_Src;
  logic [31:0] Imm_Ext;
  logic        Illegal;

  modport slave (
    input  Instr, Instr_Valid, Zero, Mem_Ready,
    output Instr_Ready, RR1, RR2, WR, WE, ALU_Op, ShiftCount, ALUSrcB, WB_Sel,
           MemRead, MemWrite, PC_Inc, PC_Write, PC_Src, Imm_Ext, Illegal
  );

  modport master (
    output Instr, Instr_Valid, Zero, Mem_Ready,
    input  Instr_Ready, RR1, RR2, WR, WE, ALU_Op, ShiftCount, ALUSrcB, WB_Sel,
           MemRead, MemWrite, PC_Inc, PC_Write, PC_Src, Imm_Ext, Illegal
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM: latches one instruction per handshake and
// sequences decode/execute/memory/write-back with Moore-decoded controls.
module mc_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter bit          SUPPRESS_R0 = 1'b1
) (
  input logic              Clk,
  input logic              Rst_n,
  mc_control_unit_if.slave bus
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_R_WB, S_EXEC_I, S_I_WB, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WR, S_MEM_WB, S_BRANCH, S_JUMP, S_ILLEGAL
  } state_e;

  localparam logic [5:0] OP_R    = 6'h00, OP_J    = 6'h02, OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C, OP_ORI  = 6'h0D, OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SRL = 4'b1101, ALU_SLL = 4'b1110, ALU_SRA = 4'b1111;
  localparam logic [15:0] TIMEOUT_LIM = 16'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [15:0] cnt_q, cnt_d;

  logic [5:0]  opcode_s, funct_s;
  logic [4:0]  rs_s, rt_s, rd_s, shamt_s;
  logic        shift_s;
  logic [31:0] imm_ext_s;

  assign opcode_s = ir_q[31:26];
  assign rs_s     = ir_q[25:21];
  assign rt_s     = ir_q[20:16];
  assign rd_s     = ir_q[15:11];
  assign shamt_s  = ir_q[10:6];
  assign funct_s  = ir_q[5:0];
  assign shift_s  = (funct_s == 6'h00) || (funct_s == 6'h02) || (funct_s == 6'h03);
  assign imm_ext_s = ((opcode_s == OP_ANDI) || (opcode_s == OP_ORI)) ?
                     {16'd0, ir_q[15:0]} : {{16{ir_q[15]}}, ir_q[15:0]};

  function automatic logic r_funct_ok(input logic [5:0] f);
    case (f)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] r_alu_op(input logic [5:0] f);
    case (f)
      6'h22:   return ALU_SUB;
      6'h24:   return ALU_AND;
      6'h25:   return ALU_OR;
      6'h27:   return ALU_NOR;
      6'h2A:   return ALU_SLT;
      6'h00:   return ALU_SLL;
      6'h02:   return ALU_SRL;
      6'h03:   return ALU_SRA;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [3:0] i_alu_op(input logic [5:0] op);
    case (op)
      OP_SLTI: return ALU_SLT;
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic wr_ok(input logic [4:0] dst);
    return !(SUPPRESS_R0 && (dst == 5'd0));
  endfunction

  // State, instruction register and memory-wait counter.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= S_FETCH;
      ir_q    <= 32'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_FETCH: begin
        if (bus.Instr_Valid) begin
          ir_d    = bus.Instr;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode_s)
          OP_R:                              state_d = r_funct_ok(funct_s) ? S_EXEC_R : S_ILLEGAL;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_EXEC_I;
          OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          default:                           state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R:   state_d = S_R_WB;
      S_EXEC_I:   state_d = S_I_WB;
      S_MEM_ADDR: state_d = (opcode_s == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD, S_MEM_WR: begin
        // A zero limit disables the abort; the counter just wraps.
        if (bus.Mem_Ready) begin
          cnt_d   = 16'd0;
          state_d = (state_q == S_MEM_RD) ? S_MEM_WB : S_FETCH;
        end else if ((TIMEOUT_LIM != 16'd0) && ((cnt_q + 16'd1) == TIMEOUT_LIM)) begin
          cnt_d   = 16'd0;
          state_d = S_ILLEGAL;
        end else begin
          cnt_d   = cnt_q + 16'd1;
        end
      end
      S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_ILLEGAL: state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // Moore output decode; PC_Inc fires in DECODE, the cycle after the accept edge.
  always_comb begin
    bus.Instr_Ready = 1'b0;
    bus.RR1         = 5'd0;
    bus.RR2         = 5'd0;
    bus.WR          = 5'd0;
    bus.WE          = 1'b0;
    bus.ALU_Op      = 4'b0000;
    bus.ShiftCount  = 5'd0;
    bus.ALUSrcB     = 2'b00;
    bus.WB_Sel      = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.PC_Inc      = 1'b0;
    bus.PC_Write    = 1'b0;
    bus.PC_Src      = 2'b00;
    bus.Imm_Ext     = 32'd0;
    bus.Illegal     = 1'b0;
    if (Rst_n) begin
      case (state_q)
        S_FETCH: bus.Instr_Ready = 1'b1;
        S_DECODE: begin
          bus.PC_Inc  = 1'b1;
          bus.RR1     = rs_s;
          bus.RR2     = rt_s;
          bus.Imm_Ext = imm_ext_s;
        end
        S_EXEC_R, S_R_WB: begin
          bus.RR1        = shift_s ? rt_s : rs_s;
          bus.RR2        = rt_s;
          bus.ALU_Op     = r_alu_op(funct_s);
          bus.ShiftCount = shift_s ? shamt_s : 5'd0;
          bus.Imm_Ext    = imm_ext_s;
          bus.WR         = (state_q == S_R_WB) ? rd_s : 5'd0;
          bus.WE         = (state_q == S_R_WB) && wr_ok(rd_s);
        end
        S_EXEC_I, S_I_WB: begin
          bus.RR1     = rs_s;
          bus.RR2     = rt_s;
          bus.ALU_Op  = i_alu_op(opcode_s);
          bus.ALUSrcB = 2'b10;
          bus.Imm_Ext = imm_ext_s;
          bus.WR      = (state_q == S_I_WB) ? rt_s : 5'd0;
          bus.WE      = (state_q == S_I_WB) && wr_ok(rt_s);
        end
        S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_MEM_WB: begin
          bus.RR1      = rs_s;
          bus.RR2      = rt_s;
          bus.ALU_Op   = ALU_ADD;
          bus.ALUSrcB  = 2'b10;
          bus.Imm_Ext  = imm_ext_s;
          bus.MemRead  = (state_q == S_MEM_RD);
          bus.MemWrite = (state_q == S_MEM_WR);
          bus.WB_Sel   = (state_q == S_MEM_WB);
          bus.WR       = (state_q == S_MEM_WB) ? rt_s : 5'd0;
          bus.WE       = (state_q == S_MEM_WB) && wr_ok(rt_s);
        end
        S_BRANCH: begin
          bus.RR1      = rs_s;
          bus.RR2      = rt_s;
          bus.ALU_Op   = ALU_SUB;
          bus.Imm_Ext  = imm_ext_s;
          bus.PC_Src   = 2'b01;
          bus.PC_Write = (opcode_s == OP_BEQ) ? bus.Zero : ~bus.Zero;
        end
        S_JUMP: begin
          bus.PC_Write = 1'b1;
          bus.PC_Src   = 2'b10;
        end
        S_ILLEGAL: bus.Illegal = 1'b1;
        default:   bus.Instr_Ready = 1'b0;
      endcase
    end else begin
      bus.Instr_Ready = 1'b0;
    end
  end
endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: hand-computed control values per state,
// plus a second instance with a short memory timeout.
module tb_mc_control_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mc_control_unit_if bus ();
  mc_control_unit_if bus2 ();

  mc_control_unit #(.MEM_TIMEOUT(16), .SUPPRESS_R0(1'b1)) dut (
    .Clk(clk), .Rst_n(rst_n), .bus(bus)
  );
  mc_control_unit #(.MEM_TIMEOUT(2), .SUPPRESS_R0(1'b1)) dut2 (
    .Clk(clk), .Rst_n(rst_n), .bus(bus2)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int rd_cycles, rd2, ill2, we2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction for one edge; returns with the DUT in DECODE.
  task automatic issue(input logic [31:0] ins);
    check("ready_at_issue", 32'(bus.Instr_Ready), 32'd1);
    bus.Instr       = ins;
    bus.Instr_Valid = 1'b1;
    step();
    bus.Instr_Valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Instr = 32'd0;  bus.Instr_Valid = 1'b0;  bus.Zero = 1'b0;  bus.Mem_Ready = 1'b0;
    bus2.Instr = 32'd0; bus2.Instr_Valid = 1'b0; bus2.Zero = 1'b0; bus2.Mem_Ready = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    check("rst_ready", 32'(bus.Instr_Ready), 32'd0);
    check("rst_we", 32'(bus.WE), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(bus.Instr_Ready), 32'd1);

    // add $3,$1,$2 with a stray Instr_Valid during EXEC_R
    issue(32'h00221820);
    check("add_rr1", 32'(bus.RR1), 32'd1);
    check("add_rr2", 32'(bus.RR2), 32'd2);
    check("add_pcinc", 32'(bus.PC_Inc), 32'd1);
    check("add_dec_ready", 32'(bus.Instr_Ready), 32'd0);
    step();
    check("add_aluop", 32'(bus.ALU_Op), 32'h2);
    check("add_srcb", 32'(bus.ALUSrcB), 32'd0);
    check("add_exec_we", 32'(bus.WE), 32'd0);
    bus.Instr = 32'hFC000000;
    bus.Instr_Valid = 1'b1;
    step();
    bus.Instr_Valid = 1'b0;
    check("add_wr", 32'(bus.WR), 32'd3);
    check("add_we", 32'(bus.WE), 32'd1);
    check("add_wbsel", 32'(bus.WB_Sel), 32'd0);
    check("add_wb_aluop", 32'(bus.ALU_Op), 32'h2);
    step();
    check("add_done_we", 32'(bus.WE), 32'd0);
    check("add_done_ready", 32'(bus.Instr_Ready), 32'd1);

    // sll $5,$0,2
    issue(32'h00002880);
    step();
    check("sll_sh", 32'(bus.ShiftCount), 32'd2);
    check("sll_aluop", 32'(bus.ALU_Op), 32'hE);
    check("sll_rr1", 32'(bus.RR1), 32'd0);
    step();
    check("sll_wr", 32'(bus.WR), 32'd5);
    check("sll_we", 32'(bus.WE), 32'd1);
    step();

    // srl $6,$7,3 with rs=1: RR1 must follow rt
    issue(32'h002730C2);
    step();
    check("srl_rr1", 32'(bus.RR1), 32'd7);
    check("srl_sh", 32'(bus.ShiftCount), 32'd3);
    check("srl_aluop", 32'(bus.ALU_Op), 32'hD);
    step();
    step();

    // addi $0,$0,7: write suppressed
    issue(32'h20000007);
    step();
    check("addi0_srcb", 32'(bus.ALUSrcB), 32'd2);
    check("addi0_aluop", 32'(bus.ALU_Op), 32'h2);
    step();
    check("addi0_we", 32'(bus.WE), 32'd0);
    step();
    check("addi0_ready", 32'(bus.Instr_Ready), 32'd1);

    // lw $4,8($1) with Mem_Ready low for 3 cycles
    issue(32'h8C240008);
    check("lw_imm", bus.Imm_Ext, 32'd8);
    step();
    check("lw_addr_aluop", 32'(bus.ALU_Op), 32'h2);
    check("lw_addr_srcb", 32'(bus.ALUSrcB), 32'd2);
    step();
    rd_cycles = 0;
    for (int i = 0; i < 20 && bus.MemRead; i++) begin
      rd_cycles++;
      bus.Mem_Ready = (rd_cycles == 4);
      step();
    end
    bus.Mem_Ready = 1'b0;
    check("lw_memread_cycles", 32'(rd_cycles), 32'd4);
    check("lw_wbsel", 32'(bus.WB_Sel), 32'd1);
    check("lw_wr", 32'(bus.WR), 32'd4);
    check("lw_we", 32'(bus.WE), 32'd1);
    step();
    check("lw_ready", 32'(bus.Instr_Ready), 32'd1);

    // sw $4,8($1) with immediate Mem_Ready
    issue(32'hAC240008);
    step();
    step();
    check("sw_memwrite", 32'(bus.MemWrite), 32'd1);
    check("sw_memread", 32'(bus.MemRead), 32'd0);
    bus.Mem_Ready = 1'b1;
    step();
    bus.Mem_Ready = 1'b0;
    check("sw_ready", 32'(bus.Instr_Ready), 32'd1);
    check("sw_memwrite_off", 32'(bus.MemWrite), 32'd0);

    // lw on the MEM_TIMEOUT=2 instance, memory never answers
    bus2.Instr = 32'h8C240008;
    bus2.Instr_Valid = 1'b1;
    step();
    bus2.Instr_Valid = 1'b0;
    step();
    step();
    rd2 = 0; ill2 = 0; we2 = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus2.MemRead) rd2++;
      if (bus2.Illegal) ill2++;
      if (bus2.WE) we2++;
      step();
    end
    check("to_memread_cycles", 32'(rd2), 32'd2);
    check("to_illegal_pulses", 32'(ill2), 32'd1);
    check("to_we_cycles", 32'(we2), 32'd0);
    check("to_ready", 32'(bus2.Instr_Ready), 32'd1);

    // beq with Zero=1 -> taken
    issue(32'h10220003);
    step();
    bus.Zero = 1'b1;
    #1;
    check("beq_pcwrite", 32'(bus.PC_Write), 32'd1);
    check("beq_pcsrc", 32'(bus.PC_Src), 32'd1);
    check("beq_aluop", 32'(bus.ALU_Op), 32'h6);
    step();
    bus.Zero = 1'b0;

    // bne: Zero=1 not taken, Zero=0 taken
    issue(32'h14220003);
    step();
    bus.Zero = 1'b1;
    #1;
    check("bne_z1_pcwrite", 32'(bus.PC_Write), 32'd0);
    bus.Zero = 1'b0;
    #1;
    check("bne_z0_pcwrite", 32'(bus.PC_Write), 32'd1);
    step();

    // andi $1,$2,FFFFh zero-extends
    issue(32'h3041FFFF);
    check("andi_imm", bus.Imm_Ext, 32'h0000FFFF);
    step();
    check("andi_aluop", 32'(bus.ALU_Op), 32'h0);
    step();
    check("andi_wr", 32'(bus.WR), 32'd1);
    check("andi_we", 32'(bus.WE), 32'd1);
    step();

    // addi $1,$2,FFFEh sign-extends
    issue(32'h2041FFFE);
    check("addi_imm", bus.Imm_Ext, 32'hFFFFFFFE);
    step();
    step();
    step();

    // j
    issue(32'h08000010);
    step();
    check("j_pcwrite", 32'(bus.PC_Write), 32'd1);
    check("j_pcsrc", 32'(bus.PC_Src), 32'd2);
    step();
    check("j_ready", 32'(bus.Instr_Ready), 32'd1);

    // opcode 3Fh -> one-cycle Illegal, back in FETCH after 3 cycles
    issue(32'hFC000000);
    check("ill_dec", 32'(bus.Illegal), 32'd0);
    step();
    check("ill_pulse", 32'(bus.Illegal), 32'd1);
    step();
    check("ill_after", 32'(bus.Illegal), 32'd0);
    check("ill_ready", 32'(bus.Instr_Ready), 32'd1);

    // unsupported R-type funct
    issue(32'h0000003F);
    step();
    check("badfunct_illegal", 32'(bus.Illegal), 32'd1);
    step();

    // reset asserted during R_WB
    issue(32'h00221820);
    step();
    step();
    check("rst_mid_we_before", 32'(bus.WE), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_we_low", 32'(bus.WE), 32'd0);
    check("rst_mid_ready_low", 32'(bus.Instr_Ready), 32'd0);
    step();
    check("rst_mid_we_edge", 32'(bus.WE), 32'd0);
    check("rst_mid_ready_edge", 32'(bus.Instr_Ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_mid_fetch", 32'(bus.Instr_Ready), 32'd1);
    check("rst_mid_we_rel", 32'(bus.WE), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
